// File: rtl/shift_pkg.sv
// Shared types and instruction field positions for the shift-control decoder.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_LSL  = 3'd0,
    OP_LSR  = 3'd1,
    OP_ASR  = 3'd2,
    OP_ROR  = 3'd3,
    OP_RRX  = 3'd4,
    OP_PASS = 3'd7
  } sh_op_t;

  typedef enum logic [1:0] {
    RNG_LT32 = 2'd0,
    RNG_EQ32 = 2'd1,
    RNG_GT32 = 2'd2
  } sh_range_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RS_WAIT = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  // Operand-2 field positions inside the instruction word.
  localparam int I_BIT         = 25;
  localparam int REG_SHIFT_BIT = 4;
  localparam int TYPE_LO       = 5;
  localparam int IMM5_LO       = 7;
  localparam int RS_LO         = 8;
  localparam int ROT_LO        = 8;
  localparam int IMM8_LO       = 0;
  localparam int RM_LO         = 0;

endpackage

// File: rtl/shift_amt_classify.sv
// Maps a shift type and 8-bit amount to {opcode, 5-bit amount, range}.
// imm_mode selects the imm5=0 special encodings (LSR/ASR #32, RRX, PASS);
// otherwise the amount is a register value n with n=0 meaning no shift.
module shift_amt_classify
  import shift_pkg::*;
#(
  parameter logic [2:0] PASS_OP = 3'h7
) (
  input  logic [1:0] shift_type,
  input  logic [7:0] amt,
  input  logic       imm_mode,
  output logic [2:0] opcode,
  output logic [4:0] amount,
  output logic [1:0] range
);

  // Classify the requested shift distance into the shift unit's encoding.
  always_comb begin
    opcode = {1'b0, shift_type};
    amount = 5'd0;
    range  = RNG_LT32;
    if (imm_mode) begin
      amount = amt[4:0];
      if (amt[4:0] == 5'd0) begin
        case (shift_type)
          2'd0:    opcode = PASS_OP;
          2'd3:    opcode = OP_RRX;
          default: range  = RNG_EQ32;
        endcase
      end
    end else if (amt == 8'd0) begin
      opcode = PASS_OP;
    end else if (shift_type == 2'd3) begin
      // Rotation wraps modulo 32; a nonzero multiple of 32 is a full rotate.
      amount = amt[4:0];
      if (amt[4:0] == 5'd0) range = RNG_EQ32;
    end else if (amt < 8'd32) begin
      amount = amt[4:0];
    end else if (amt == 8'd32) begin
      range = RNG_EQ32;
    end else begin
      range = RNG_GT32;
    end
  end

endmodule

// File: rtl/shift_ctrl_decoder.sv
// Decodes the operand-2 field into registered shift-unit controls with a
// valid/ready output. Register-specified shifts spend one extra cycle
// waiting for Rs from the dedicated register-file read port.
module shift_ctrl_decoder
  import shift_pkg::*;
#(
  parameter int         RF_LAT  = 1,
  parameter logic [2:0] PASS_OP = 3'h7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        rs_rd_en,
  output logic [3:0]  rs_addr,
  input  logic [31:0] rs_data,
  output logic        sh_valid,
  input  logic        sh_ready,
  output logic [2:0]  sh_opcode,
  output logic [4:0]  sh_amount,
  output logic [1:0]  sh_range,
  output logic        sh_imm_sel,
  output logic [31:0] sh_imm,
  output logic [3:0]  sh_rm
);

  if (RF_LAT != 1) begin : g_rf_lat_check
    $error("shift_ctrl_decoder: only RF_LAT=1 is supported");
  end

  state_t     state;
  logic [1:0] pend_type;
  logic       accept;
  logic       reg_form;
  logic [1:0] cls_type;
  logic [7:0] cls_amt;
  logic       cls_imm_mode;
  logic [2:0] cls_op;
  logic [4:0] cls_amount;
  logic [1:0] cls_range;
  logic       unused_bits;

  assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[31:8]};

  assign in_ready = (state == ST_IDLE) | ((state == ST_OUT) & sh_ready);
  assign accept   = in_valid & in_ready;
  assign reg_form = ~instr[I_BIT] & instr[REG_SHIFT_BIT];

  // The read is issued in the accept cycle so Rs arrives during RS_WAIT.
  assign rs_rd_en = accept & reg_form;
  assign rs_addr  = rs_rd_en ? instr[RS_LO +: 4] : 4'd0;

  // One classifier serves both paths: RS_WAIT never overlaps an accept.
  always_comb begin
    cls_type     = instr[TYPE_LO +: 2];
    cls_amt      = {3'b000, instr[IMM5_LO +: 5]};
    cls_imm_mode = 1'b1;
    if (state == ST_RS_WAIT) begin
      cls_type     = pend_type;
      cls_amt      = rs_data[7:0];
      cls_imm_mode = 1'b0;
    end
  end

  shift_amt_classify #(
    .PASS_OP(PASS_OP)
  ) u_classify (
    .shift_type(cls_type),
    .amt       (cls_amt),
    .imm_mode  (cls_imm_mode),
    .opcode    (cls_op),
    .amount    (cls_amount),
    .range     (cls_range)
  );

  // Control FSM with registered shift-unit outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pend_type  <= 2'd0;
      sh_valid   <= 1'b0;
      sh_opcode  <= 3'd0;
      sh_amount  <= 5'd0;
      sh_range   <= 2'd0;
      sh_imm_sel <= 1'b0;
      sh_imm     <= 32'd0;
      sh_rm      <= 4'd0;
    end else if (accept) begin
      sh_rm <= instr[RM_LO +: 4];
      if (instr[I_BIT]) begin
        state      <= ST_OUT;
        sh_valid   <= 1'b1;
        sh_imm_sel <= 1'b1;
        sh_imm     <= {24'd0, instr[IMM8_LO +: 8]};
        sh_opcode  <= (instr[ROT_LO +: 4] == 4'd0) ? PASS_OP : OP_ROR;
        sh_amount  <= {instr[ROT_LO +: 4], 1'b0};
        sh_range   <= RNG_LT32;
      end else if (!instr[REG_SHIFT_BIT]) begin
        state      <= ST_OUT;
        sh_valid   <= 1'b1;
        sh_imm_sel <= 1'b0;
        sh_imm     <= 32'd0;
        sh_opcode  <= cls_op;
        sh_amount  <= cls_amount;
        sh_range   <= cls_range;
      end else begin
        state     <= ST_RS_WAIT;
        sh_valid  <= 1'b0;
        pend_type <= instr[TYPE_LO +: 2];
      end
    end else begin
      case (state)
        ST_RS_WAIT: begin
          state      <= ST_OUT;
          sh_valid   <= 1'b1;
          sh_imm_sel <= 1'b0;
          sh_imm     <= 32'd0;
          sh_opcode  <= cls_op;
          sh_amount  <= cls_amount;
          sh_range   <= cls_range;
        end
        ST_OUT: begin
          if (sh_ready) begin
            state    <= ST_IDLE;
            sh_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
